// File: rtl/loader_pkg.sv
// loader_pkg: shared definitions for the program loader slice.
//   - state_t and ST_* constants: framing FSM encoding (plain logic constants
//     so existing code that compares raw state codes keeps working).
//   - SYNC_BYTE_DEFAULT: default frame start marker.
//   - LP_* : bit positions inside the core's load_program word.
//   - pack_load(): builds a load_program word with load_en set.
package loader_pkg;

  typedef logic [3:0] state_t;

  localparam state_t ST_IDLE    = 4'd0;
  localparam state_t ST_CNT_H   = 4'd1;
  localparam state_t ST_CNT_L   = 4'd2;
  localparam state_t ST_ADR_H   = 4'd3;
  localparam state_t ST_ADR_L   = 4'd4;
  localparam state_t ST_DAT_H   = 4'd5;
  localparam state_t ST_DAT_L   = 4'd6;
  localparam state_t ST_HOLD    = 4'd7;
  localparam state_t ST_CHK     = 4'd8;
  localparam state_t ST_RELEASE = 4'd9;
  localparam state_t ST_DONE    = 4'd10;
  localparam state_t ST_ERROR   = 4'd11;

  localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;

  localparam int LP_EN_BIT   = 31;
  localparam int LP_ADDR_MSB = 27;
  localparam int LP_ADDR_LSB = 16;
  localparam int LP_DATA_MSB = 15;

  // Word presented to the core for one memory write; bits [30:28] stay zero.
  function automatic logic [31:0] pack_load(input logic [11:0] addr,
                                            input logic [15:0] data);
    logic [31:0] w;
    w                            = '0;
    w[LP_EN_BIT]                 = 1'b1;
    w[LP_ADDR_MSB:LP_ADDR_LSB]   = addr;
    w[LP_DATA_MSB:0]             = data;
    return w;
  endfunction

endpackage

// File: rtl/program_loader_if.sv
// program_loader_if: byte stream handshake from the serial receiver.
//   rx_data  : received byte
//   rx_valid : rx_data is valid (source holds the byte until accepted)
//   rx_ready : sink accepts a byte; a transfer happens when both are high
// Modports: master = byte source, slave = loader.
interface program_loader_if;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;

  modport master (output rx_data, output rx_valid, input  rx_ready);
  modport slave  (input  rx_data, input  rx_valid, output rx_ready);
endinterface

// File: rtl/loader_hold_timer.sv
// loader_hold_timer: down-counter shared by the HOLD and RELEASE phases.
//   clk, reset : clock, synchronous active-low reset
//   load       : load value into the counter this cycle
//   value      : cycles-minus-one to count
//   expired    : counter has reached zero (phase ends on this cycle)
module loader_hold_timer #(
  parameter int WIDTH = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] value,
  output logic             expired
);

  logic [WIDTH-1:0] count;

  always_ff @(posedge clk) begin
    if (!reset) begin
      count <= '0;
    end else if (load) begin
      count <= value;
    end else if (count != '0) begin
      count <= count - WIDTH'(1);
    end
  end

  assign expired = (count == '0);

endmodule

// File: rtl/program_loader.sv
// program_loader: decodes a framed program image from a byte stream, writes
// it into the 16-bit core through load_program and then sequences the core's
// reset so it restarts at PC 0 on a fully loaded memory.
// Frame (big-endian): SYNC, CNT_HI, CNT_LO, ADR_HI, ADR_LO, CNT x {DATA_HI, DATA_LO}
//   [, CHK when LOADER_CHECKSUM_EN is defined: XOR of all bytes after SYNC,
//      checksum included, must be 8'h00].
// Ports:
//   clk, reset   : clock, synchronous active-low reset
//   rx           : byte stream handshake (program_loader_if.slave)
//   load_program : {load_en, 3'b000, addr[11:0], data[15:0]} to the core
//   cpu_rst_n    : core reset, active-low; low until the first image is released
//   busy         : frame in progress
//   loaded       : last image has been released to the core
//   error        : checksum failure (always 0 without LOADER_CHECKSUM_EN)
//   words_loaded : words written in the current frame
// Optional feature macro: LOADER_CHECKSUM_EN.
module program_loader
  import loader_pkg::*;
#(
  parameter logic [7:0] SYNC_BYTE   = SYNC_BYTE_DEFAULT,
  parameter int         HOLD_CYCLES = 2,
  parameter int         RST_CYCLES  = 4
) (
  input  logic            clk,
  input  logic            reset,
  program_loader_if.slave rx,
  output logic [31:0]     load_program,
  output logic            cpu_rst_n,
  output logic            busy,
  output logic            loaded,
  output logic            error,
  output logic [11:0]     words_loaded
);

  localparam int TMR_MAX = (HOLD_CYCLES > RST_CYCLES) ? HOLD_CYCLES : RST_CYCLES;
  localparam int TMR_W   = (TMR_MAX > 2) ? $clog2(TMR_MAX) : 1;

  // State reached once the last data word (or ADR_L for an empty image) is done.
`ifdef LOADER_CHECKSUM_EN
  localparam state_t ST_TAIL = ST_CHK;
`else
  localparam state_t ST_TAIL = ST_RELEASE;
`endif

  state_t           state;
  logic [11:0]      count;
  logic [11:0]      cur_addr;
  logic [7:0]       data_hi;
  logic             accept;
  logic             is_sync;
  logic             hold_start;
  logic             go_release;
  logic             tmr_load;
  logic [TMR_W-1:0] tmr_value;
  logic             tmr_expired;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]       chk;
`endif

  // No byte is taken while a word is being held or the core is in reset.
  assign rx.rx_ready = reset && (state != ST_HOLD) && (state != ST_RELEASE);
  assign busy        = !(state inside {ST_IDLE, ST_DONE, ST_ERROR});
  assign accept      = rx.rx_valid && rx.rx_ready;
  assign is_sync     = accept && (rx.rx_data == SYNC_BYTE);
  assign hold_start  = (state == ST_DAT_L) && accept;

  always_comb begin
    // NOTE: give every always_comb output a default first; a path that leaves
    // it unassigned would infer a latch.
    go_release = 1'b0;
    case (state)
`ifdef LOADER_CHECKSUM_EN
      ST_CHK:   go_release = accept && ((chk ^ rx.rx_data) == 8'h00);
`else
      ST_ADR_L: go_release = accept && (count == '0);
      ST_HOLD:  go_release = tmr_expired && (words_loaded == count);
`endif
      default:  go_release = 1'b0;
    endcase
  end

  assign tmr_load  = hold_start || go_release;
  assign tmr_value = go_release ? TMR_W'(RST_CYCLES - 1) : TMR_W'(HOLD_CYCLES - 1);

  loader_hold_timer #(.WIDTH(TMR_W)) u_timer (
    .clk     (clk),
    .reset   (reset),
    .load    (tmr_load),
    .value   (tmr_value),
    .expired (tmr_expired)
  );

  // NOTE: sequential state uses non-blocking assignments so every register in
  // this block reacts to the pre-edge values of the others.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state        <= ST_IDLE;
      count        <= '0;
      cur_addr     <= '0;
      data_hi      <= '0;
      load_program <= '0;
      cpu_rst_n    <= 1'b0;
      loaded       <= 1'b0;
      words_loaded <= '0;
`ifdef LOADER_CHECKSUM_EN
      chk          <= '0;
      error        <= 1'b0;
`endif
    end else begin
      case (state)
        // cpu_rst_n is left alone here: after a release it stays high while
        // reloading because load_en overrides execution in the core.
        ST_IDLE, ST_DONE, ST_ERROR: begin
          if (is_sync) begin
            state        <= ST_CNT_H;
            loaded       <= 1'b0;
            words_loaded <= '0;
`ifdef LOADER_CHECKSUM_EN
            chk          <= '0;
            error        <= 1'b0;
`endif
          end
        end
        ST_CNT_H: if (accept) begin
          count[11:8] <= rx.rx_data[3:0];
          state       <= ST_CNT_L;
        end
        ST_CNT_L: if (accept) begin
          count[7:0] <= rx.rx_data;
          state      <= ST_ADR_H;
        end
        ST_ADR_H: if (accept) begin
          cur_addr[11:8] <= rx.rx_data[3:0];
          state          <= ST_ADR_L;
        end
        ST_ADR_L: if (accept) begin
          cur_addr[7:0] <= rx.rx_data;
          state         <= (count == '0) ? ST_TAIL : ST_DAT_H;
        end
        // The previous word stays on load_program while waiting for bytes.
        ST_DAT_H: if (accept) begin
          data_hi <= rx.rx_data;
          state   <= ST_DAT_L;
        end
        ST_DAT_L: if (accept) begin
          load_program <= pack_load(cur_addr, {data_hi, rx.rx_data});
          words_loaded <= words_loaded + 12'd1;
          state        <= ST_HOLD;
        end
        ST_HOLD: if (tmr_expired) begin
          cur_addr <= cur_addr + 12'd1;
          state    <= (words_loaded == count) ? ST_TAIL : ST_DAT_H;
        end
`ifdef LOADER_CHECKSUM_EN
        ST_CHK: if (accept && !go_release) begin
          state        <= ST_ERROR;
          error        <= 1'b1;
          load_program <= '0;
          cpu_rst_n    <= 1'b0;
        end
`endif
        ST_RELEASE: if (tmr_expired) begin
          cpu_rst_n <= 1'b1;
          loaded    <= 1'b1;
          state     <= ST_DONE;
        end
        default: state <= ST_IDLE;
      endcase

`ifdef LOADER_CHECKSUM_EN
      if (accept && (state inside {ST_CNT_H, ST_CNT_L, ST_ADR_H, ST_ADR_L,
                                   ST_DAT_H, ST_DAT_L})) begin
        chk <= chk ^ rx.rx_data;
      end
`endif

      // Entering RELEASE drops load_en and asserts the core reset together.
      if (go_release) begin
        state        <= ST_RELEASE;
        load_program <= '0;
        cpu_rst_n    <= 1'b0;
      end
    end
  end

`ifndef LOADER_CHECKSUM_EN
  assign error = 1'b0;
`endif

endmodule

// File: tb/tb_program_loader.sv
// tb_program_loader: randomized self-checking bench for program_loader.
// A cycle monitor records the words the core would see and the reset timing;
// each scenario compares those observations with a frame-level model.
module tb_program_loader;

  localparam int         HOLD = 2;
  localparam int         RSTC = 4;
  localparam logic [7:0] SYNC = 8'hA5;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] load_program;
  logic        cpu_rst_n, busy, loaded, error;
  logic [11:0] words_loaded;

  int checks = 0;
  int failures = 0;
  bit released_before = 1'b0;

  always #5 clk = ~clk;

  program_loader_if rx_if ();

  program_loader dut (
    .clk          (clk),
    .reset        (reset),
    .rx           (rx_if),
    .load_program (load_program),
    .cpu_rst_n    (cpu_rst_n),
    .busy         (busy),
    .loaded       (loaded),
    .error        (error),
    .words_loaded (words_loaded)
  );

  // ---------------- cycle monitor (samples 2 time units after posedge) -----
  logic [31:0] seen[$];
  logic [31:0] prev_lp = '0;
  int rises, drops, hold_viol, ready_viol, rel_viol, rel_cycles, rel_rst_viol, lowcnt;
  int run_len = 0, since_new = HOLD;
  int mon_gen = 0, mon_seen_gen = 0;

  always begin
    @(posedge clk);
    #2;
    if (mon_gen != mon_seen_gen) begin
      mon_seen_gen = mon_gen;
      seen.delete();
      prev_lp = '0; run_len = 0; since_new = HOLD;
      rises = 0; drops = 0; hold_viol = 0; ready_viol = 0; rel_viol = 0;
      rel_cycles = 0; rel_rst_viol = 0; lowcnt = 0;
    end
    if (load_program !== prev_lp) begin
      if (prev_lp[31] === 1'b1 && run_len < HOLD) hold_viol++;
      run_len = 1;
      if (load_program[31] === 1'b1) begin
        seen.push_back(load_program);
        since_new = 0;
      end
    end else begin
      run_len++;
      since_new++;
    end
    if (prev_lp[31] !== 1'b1 && load_program[31] === 1'b1) rises++;
    if (prev_lp[31] === 1'b1 && load_program[31] !== 1'b1) begin
      drops++;
      if (cpu_rst_n !== 1'b0) rel_viol++;
    end
    if (load_program[31] === 1'b1 && since_new < HOLD && rx_if.rx_ready !== 1'b0) ready_viol++;
    if (busy === 1'b1 && rx_if.rx_ready === 1'b0 && load_program === 32'h0) begin
      rel_cycles++;
      if (cpu_rst_n !== 1'b0) rel_rst_viol++;
    end
    if (cpu_rst_n === 1'b0) lowcnt++;
    prev_lp = load_program;
  end

  // ---------------- driver --------------------------------------------------
  task automatic send_byte(input logic [7:0] b, input bit gaps);
    int n;
    if (gaps) repeat ($urandom_range(0, 2)) @(negedge clk);
    rx_if.rx_data  = b;
    rx_if.rx_valid = 1'b1;
    n = 0;
    while (rx_if.rx_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) begin
      checks++; failures++;
      $display("FAIL send_timeout byte=%02h rx_ready=%b required=1", b, rx_if.rx_ready);
    end
    @(negedge clk);
    rx_if.rx_valid = 1'b0;
    rx_if.rx_data  = 8'($urandom);
  endtask

  // Sends one frame and compares the observed behaviour with the model.
  task automatic run_frame(input string tag, input logic [11:0] addr,
                           input logic [15:0] dq[$], input bit gaps,
                           input bit garbage, input bit junk_hi, input bit corrupt);
    logic [7:0]  fb[$];
    logic [7:0]  b;
    logic [7:0]  x;
    logic [31:0] exp_w;
    logic [3:0]  hn;
    int cnt, n, sync_idx;
    bit bad;
    cnt = dq.size();
    bad = 1'b0;
    if (garbage) begin
      fb.push_back(8'h00);
      fb.push_back(8'hFF);
      b = 8'($urandom);
      fb.push_back((b == SYNC) ? 8'h5A : b);
    end
    sync_idx = fb.size();
    fb.push_back(SYNC);
    hn = junk_hi ? 4'($urandom) : 4'h0;
    fb.push_back({hn, 4'(cnt >> 8)});
    fb.push_back(8'(cnt));
    hn = junk_hi ? 4'($urandom) : 4'h0;
    fb.push_back({hn, addr[11:8]});
    fb.push_back(addr[7:0]);
    foreach (dq[i]) begin
      fb.push_back(dq[i][15:8]);
      fb.push_back(dq[i][7:0]);
    end
`ifdef LOADER_CHECKSUM_EN
    x = 8'h00;
    for (int i = sync_idx + 1; i < fb.size(); i++) x ^= fb[i];
    bad = corrupt;
    if (corrupt) x ^= 8'($urandom_range(1, 255));
    fb.push_back(x);
`else
    x = 8'h00;
    if (corrupt) x = 8'h00;
`endif
    mon_gen++;
    @(negedge clk);
    foreach (fb[i]) send_byte(fb[i], gaps);
    n = 0;
    while (!(loaded === 1'b1 || error === 1'b1) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      checks++; failures++;
      $display("FAIL %s completion_timeout loaded=%b error=%b", tag, loaded, error);
    end
    repeat (2) @(negedge clk);

    checks++;
    if (seen.size() !== cnt) begin
      failures++;
      $display("FAIL %s word_count got=%0d required=%0d", tag, seen.size(), cnt);
    end
    for (int i = 0; i < cnt && i < seen.size(); i++) begin
      exp_w = 32'h8000_0000 | (32'((int'(addr) + i) % 4096) << 16) | 32'(dq[i]);
      checks++;
      if (seen[i] !== exp_w) begin
        failures++;
        $display("FAIL %s word[%0d] got=%08h required=%08h", tag, i, seen[i], exp_w);
      end
    end
    checks++;
    if (rises !== ((cnt > 0) ? 1 : 0) || drops !== ((cnt > 0) ? 1 : 0)) begin
      failures++;
      $display("FAIL %s load_en_continuity rises=%0d drops=%0d required=%0d", tag,
               rises, drops, (cnt > 0) ? 1 : 0);
    end
    checks++;
    if (hold_viol !== 0 || ready_viol !== 0 || rel_viol !== 0) begin
      failures++;
      $display("FAIL %s hold_rules short_hold=%0d ready_in_hold=%0d rst_not_low_at_drop=%0d required=0",
               tag, hold_viol, ready_viol, rel_viol);
    end
    if (!bad) begin
      checks++;
      if (rel_cycles !== RSTC || rel_rst_viol !== 0) begin
        failures++;
        $display("FAIL %s release_phase cycles=%0d rst_high=%0d required=%0d/0", tag,
                 rel_cycles, rel_rst_viol, RSTC);
      end
      checks++;
      if ({loaded, busy, cpu_rst_n, error, rx_if.rx_ready} !== 5'b10101 ||
          load_program !== 32'h0 || words_loaded !== 12'(cnt)) begin
        failures++;
        $display("FAIL %s final loaded=%b busy=%b cpu_rst_n=%b error=%b rx_ready=%b lp=%08h words=%0d required 1 0 1 0 1 00000000 %0d",
                 tag, loaded, busy, cpu_rst_n, error, rx_if.rx_ready, load_program,
                 words_loaded, cnt);
      end
      if (released_before) begin
        checks++;
        if (lowcnt !== RSTC) begin
          failures++;
          $display("FAIL %s reload_rst_low got=%0d required=%0d", tag, lowcnt, RSTC);
        end
      end
      released_before = 1'b1;
    end else begin
      checks++;
      if ({error, cpu_rst_n, loaded, busy, rx_if.rx_ready} !== 5'b10001 ||
          load_program !== 32'h0) begin
        failures++;
        $display("FAIL %s error_state error=%b cpu_rst_n=%b loaded=%b busy=%b rx_ready=%b lp=%08h required 1 0 0 0 1 00000000",
                 tag, error, cpu_rst_n, loaded, busy, rx_if.rx_ready, load_program);
      end
      released_before = 1'b0;
    end
  endtask

  // ---------------- scenarios ----------------------------------------------
  task automatic check_reset_outputs(input string tag);
    checks++;
    if (load_program !== 32'h0 || cpu_rst_n !== 1'b0 || rx_if.rx_ready !== 1'b0 ||
        busy !== 1'b0 || loaded !== 1'b0 || error !== 1'b0 || words_loaded !== 12'h0) begin
      failures++;
      $display("FAIL %s lp=%08h cpu_rst_n=%b rx_ready=%b busy=%b loaded=%b error=%b words=%0d required all 0",
               tag, load_program, cpu_rst_n, rx_if.rx_ready, busy, loaded, error, words_loaded);
    end
  endtask

  task automatic test_reset();
    logic [7:0] pre[$];
    reset = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset_initial");
    reset = 1'b1;
    @(negedge clk);
    pre = '{8'hA5, 8'h00, 8'h02, 8'h00, 8'h10, 8'h12, 8'h34};
    foreach (pre[i]) send_byte(pre[i], 1'b0);
    checks++;
    if (load_program !== 32'h8010_1234) begin
      failures++;
      $display("FAIL reset_prefix lp=%08h required=80101234", load_program);
    end
    reset = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset_mid_frame");
    reset = 1'b1;
    released_before = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic();
    logic [15:0] dq[$];
    dq = '{16'h1234, 16'hABCD};
    run_frame("basic", 12'h010, dq, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_reload();
    logic [15:0] dq[$];
    dq = '{16'h0F0F, 16'h5555, 16'h9ABC};
    run_frame("reload", 12'h123, dq, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_wrap();
    logic [15:0] dq[$];
    dq = '{16'hDEAD, 16'hBEEF};
    run_frame("wrap", 12'hFFF, dq, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_zero_count();
    logic [15:0] dq[$];
    dq = {};
    run_frame("zero_count", 12'h100, dq, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_garbage_gaps();
    logic [15:0] dq[$];
    dq = '{16'h1234, 16'hABCD};
    run_frame("garbage_gaps", 12'h010, dq, 1'b1, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic test_random();
    logic [15:0] dq[$];
    logic [11:0] a;
    for (int it = 0; it < 6; it++) begin
      dq = {};
      repeat ($urandom_range(1, 5)) dq.push_back(16'($urandom));
      a = (it % 2 == 1) ? 12'(12'hFFF - $urandom_range(0, 3)) : 12'($urandom);
      run_frame($sformatf("random%0d", it), a, dq, 1'b1, it[0], 1'b1, 1'b0);
    end
  endtask

`ifdef LOADER_CHECKSUM_EN
  task automatic test_checksum();
    logic [15:0] dq[$];
    dq = '{16'h4321, 16'h8765};
    run_frame("chk_bad", 12'h040, dq, 1'b1, 1'b0, 1'b0, 1'b1);
    dq = '{16'h1234};
    run_frame("chk_good", 12'h000, dq, 1'b0, 1'b0, 1'b0, 1'b0);
    dq = {};
    run_frame("chk_empty", 12'h100, dq, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask
`endif

  initial begin
    rx_if.rx_valid = 1'b0;
    rx_if.rx_data  = 8'h00;
    test_reset();
    test_basic();
    test_reload();
    test_wrap();
    test_zero_count();
    test_garbage_gaps();
    test_random();
`ifdef LOADER_CHECKSUM_EN
    test_checksum();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
